alarm_snooze_ctrl: RTL and testbench
====================================

ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

Interface
REQ-001 Parameter CLK_IN, default 5000000: input clock frequency in Hz.
REQ-002 Parameter TONE_HZ, default 1000: buzzer tone frequency in Hz.
REQ-003 Parameter SNOOZE_SECONDS, default 540: snooze interval in seconds.
REQ-004 Parameter RING_TIMEOUT_S, default 60: maximum unattended ring time in seconds.
REQ-005 Parameter MAX_SNOOZES, default 3: maximum number of snoozes per alarm event.
REQ-006 i_Clk  input  1  system clock, 5 MHz domain.
REQ-007 i_Reset_n  input  1  reset, asynchronous, active-low.
REQ-008 i_Tick_1Hz  input  1  one-cycle pulse, once per second.
REQ-009 i_Alarm_Match  input  1  level; high while time equals alarm time and the alarm is enabled.
REQ-010 i_Alarm_Enable  input  1  level; alarm armed switch.
REQ-011 i_Snooze  input  1  debounced one-cycle pulse.
REQ-012 i_Stop  input  1  debounced one-cycle pulse.
REQ-013 o_Buzzer  output  1  buzzer drive.
REQ-014 o_Ringing  output  1  high in RINGING.
REQ-015 o_Snoozing  output  1  high in SNOOZE.
REQ-016 o_Snooze_Remaining  output  10  seconds left in the current snooze; 0 outside SNOOZE.

Function
REQ-017 The FSM SHALL have the states IDLE, RINGING, SNOOZE and DONE, all registered.
REQ-018 IDLE->RINGING SHALL occur on the rising edge of i_Alarm_Match (registered edge detect), with a latency of 1 cycle from the edge to o_Ringing=1.
REQ-019 RINGING SHALL clear the ring-seconds counter on entry and increment it on each i_Tick_1Hz.
REQ-020 RINGING->DONE SHALL occur on i_Stop, or when the ring-seconds counter reaches RING_TIMEOUT_S.
REQ-021 RINGING->SNOOZE SHALL occur on i_Snooze when snooze_count<MAX_SNOOZES, loading SNOOZE_SECONDS into the remaining counter and incrementing snooze_count; when snooze_count=MAX_SNOOZES, i_Snooze SHALL be ignored.
REQ-022 SNOOZE SHALL decrement the remaining counter on each i_Tick_1Hz.
REQ-023 SNOOZE SHALL go to RINGING on the tick that takes the remaining counter from 1 to 0.
REQ-024 i_Snooze in SNOOZE SHALL be ignored.
REQ-025 i_Stop in SNOOZE SHALL go to DONE.
REQ-026 DONE->IDLE SHALL occur when i_Alarm_Match=0; this prevents re-trigger within the same matching second.
REQ-027 i_Alarm_Enable=0 SHALL force IDLE from any state on the next edge, clear snooze_count, and take priority over all other inputs.
REQ-028 When i_Stop and i_Snooze are asserted in the same cycle, i_Stop SHALL win.
REQ-029 When i_Tick_1Hz coincides with i_Snooze in RINGING, the state SHALL become SNOOZE and the tick SHALL NOT decrement the freshly loaded count.
REQ-030 snooze_count SHALL clear on entry to IDLE.
REQ-031 In RINGING, o_Buzzer SHALL be gated by a beat bit that toggles on each i_Tick_1Hz, starting at 1 on entry.
REQ-032 o_Buzzer SHALL be 0 in every state other than RINGING.
REQ-033 All counters SHALL saturate and never wrap.
REQ-034 All counter widths SHALL be sized with $clog2 of their respective parameters.

Reset
REQ-035 Assertion of i_Reset_n=0 SHALL set the state to IDLE, clear all counters and the beat bit, and set o_Buzzer, o_Ringing, o_Snoozing and o_Snooze_Remaining to 0.
REQ-036 Reset mid-ring or mid-snooze SHALL abandon the event, and the alarm SHALL NOT re-ring until a new rising edge of i_Alarm_Match.

Configuration
REQ-037 With ALARM_SNOOZE_TONE_EN defined, o_Buzzer SHALL equal beat AND a TONE_HZ 50% square wave derived from CLK_IN, with the tone phase reset on RINGING entry.
REQ-038 Without ALARM_SNOOZE_TONE_EN, o_Buzzer SHALL equal beat (a steady level for an active buzzer) and no tone counter SHALL be synthesised.

Structure
REQ-039 The state encoding, SNOOZE_SECONDS and RING_TIMEOUT_S defaults, and the counter width constants SHALL reside in the shared package alarm_clock_pkg.
REQ-040 The tone divider SHALL be the sub-module tone_gen (ports: clock, reset, enable, tone out), instantiated only under ALARM_SNOOZE_TONE_EN.

Verification
REQ-041 Scenario: rise i_Alarm_Match -> o_Ringing=1 after 1 cycle; o_Buzzer toggles with the beat on each tick.
REQ-042 Scenario: RINGING, pulse i_Snooze, then 540 ticks -> o_Snooze_Remaining steps 540..1, and RINGING re-enters on tick 540 (use SNOOZE_SECONDS=5 for a short run).
REQ-043 Scenario: four snoozes with MAX_SNOOZES=3 -> the fourth snooze is ignored, RINGING persists, and DONE follows 60 ticks later.
REQ-044 Scenario: i_Stop and i_Snooze in the same cycle -> DONE; DONE holds while i_Alarm_Match=1 and returns to IDLE when it falls.
REQ-045 Scenario: drop i_Alarm_Enable in SNOOZE -> IDLE next cycle, o_Snooze_Remaining=0, o_Buzzer=0.
REQ-046 Scenario: assert i_Reset_n=0 mid-RINGING -> all outputs 0 immediately (asynchronous); a held i_Alarm_Match SHALL NOT re-trigger.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: FSM state encoding, default timing
// constants and the counter width helper used by the snooze controller
// and its tone generator.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2,
    ST_DONE    = 2'd3
  } alarm_state_t;

  localparam int SNOOZE_SECONDS_DEF = 540;
  localparam int RING_TIMEOUT_S_DEF = 60;
  localparam int MAX_SNOOZES_DEF    = 3;

  // Width of the external seconds-remaining bus.
  localparam int REMAIN_OUT_W = 10;

  // Bits needed to hold every value 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int REM_W_DEF  = cnt_w(SNOOZE_SECONDS_DEF);
  localparam int RING_W_DEF = cnt_w(RING_TIMEOUT_S_DEF);
  localparam int SCNT_W_DEF = cnt_w(MAX_SNOOZES_DEF);

endpackage

// File: rtl/tone_gen.sv
// 50% duty square-wave divider producing TONE_HZ from CLK_IN.
// While disabled the phase is held at the start of a high half-period,
// so every enable begins with a full high half-cycle.
module tone_gen
  import alarm_clock_pkg::*;
#(
  parameter int CLK_IN  = 5000000,
  parameter int TONE_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tone
);

  localparam int HALF_RAW = CLK_IN / (2 * TONE_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int DIV_W    = cnt_w(HALF);

  logic [DIV_W-1:0] div_cnt;

  // Half-period counter; toggles the tone each time it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tone    <= 1'b1;
    end else if (!en) begin
      div_cnt <= '0;
      tone    <= 1'b1;
    end else if (div_cnt == DIV_W'(HALF - 1)) begin
      div_cnt <= '0;
      tone    <= ~tone;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ring / snooze / stop controller.
// Optional feature macro ALARM_SNOOZE_TONE_EN: when defined, the buzzer is
// the beat gated by a TONE_HZ square wave from tone_gen (passive buzzer);
// otherwise the buzzer is the beat level itself (active buzzer).
module alarm_snooze_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int CLK_IN         = 5000000,
  parameter int TONE_HZ        = 1000,
  parameter int SNOOZE_SECONDS = SNOOZE_SECONDS_DEF,
  parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
  parameter int MAX_SNOOZES    = MAX_SNOOZES_DEF
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset_n,
  input  logic                    i_Tick_1Hz,
  input  logic                    i_Alarm_Match,
  input  logic                    i_Alarm_Enable,
  input  logic                    i_Snooze,
  input  logic                    i_Stop,
  output logic                    o_Buzzer,
  output logic                    o_Ringing,
  output logic                    o_Snoozing,
  output logic [REMAIN_OUT_W-1:0] o_Snooze_Remaining
);

  localparam int REM_W  = cnt_w(SNOOZE_SECONDS);
  localparam int RING_W = cnt_w(RING_TIMEOUT_S);
  localparam int SCNT_W = cnt_w(MAX_SNOOZES);

  // Reject tone settings the divider cannot produce.
  if (TONE_HZ < 1 || CLK_IN < 2 * TONE_HZ) begin : g_bad_tone
    $error("alarm_snooze_ctrl: CLK_IN must be at least 2*TONE_HZ");
  end

  alarm_state_t      state, state_nx;
  logic              match_d;
  logic              match_rise;
  logic [RING_W-1:0] ring_secs, ring_secs_nx;
  logic [REM_W-1:0]  rem, rem_nx;
  logic [SCNT_W-1:0] snooze_cnt, snooze_cnt_nx;
  logic              beat, beat_nx;
  logic              buzz_q;

  function automatic logic [RING_W-1:0] ring_inc_sat(input logic [RING_W-1:0] v);
    return (v >= RING_W'(RING_TIMEOUT_S)) ? v : v + 1'b1;
  endfunction

  function automatic logic [SCNT_W-1:0] scnt_inc_sat(input logic [SCNT_W-1:0] v);
    return (v >= SCNT_W'(MAX_SNOOZES)) ? v : v + 1'b1;
  endfunction

  function automatic logic [REM_W-1:0] rem_dec_sat(input logic [REM_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  assign match_rise = i_Alarm_Match & ~match_d;

  // Next-state and counter update; disable dominates, then stop, then snooze, then tick.
  always_comb begin
    state_nx      = state;
    ring_secs_nx  = ring_secs;
    rem_nx        = rem;
    snooze_cnt_nx = snooze_cnt;
    beat_nx       = beat;
    if (!i_Alarm_Enable) begin
      state_nx      = ST_IDLE;
      ring_secs_nx  = '0;
      rem_nx        = '0;
      snooze_cnt_nx = '0;
      beat_nx       = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          snooze_cnt_nx = '0;
          if (match_rise) begin
            state_nx     = ST_RINGING;
            ring_secs_nx = '0;
            beat_nx      = 1'b1;
          end
        end
        ST_RINGING: begin
          if (i_Stop) begin
            state_nx = ST_DONE;
            beat_nx  = 1'b0;
          end else if (i_Snooze && (snooze_cnt < SCNT_W'(MAX_SNOOZES))) begin
            // A coincident tick is absorbed here, so the fresh load is not decremented.
            state_nx      = ST_SNOOZE;
            rem_nx        = REM_W'(SNOOZE_SECONDS);
            snooze_cnt_nx = scnt_inc_sat(snooze_cnt);
            beat_nx       = 1'b0;
          end else if (i_Tick_1Hz) begin
            ring_secs_nx = ring_inc_sat(ring_secs);
            beat_nx      = ~beat;
            if (ring_secs_nx >= RING_W'(RING_TIMEOUT_S)) begin
              state_nx = ST_DONE;
              beat_nx  = 1'b0;
            end
          end
        end
        ST_SNOOZE: begin
          if (i_Stop) begin
            state_nx = ST_DONE;
            rem_nx   = '0;
          end else if (i_Tick_1Hz) begin
            rem_nx = rem_dec_sat(rem);
            if (rem <= REM_W'(1)) begin
              state_nx     = ST_RINGING;
              ring_secs_nx = '0;
              beat_nx      = 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Wait for the match window to close so the same second cannot re-trigger.
          if (!i_Alarm_Match) begin
            state_nx      = ST_IDLE;
            snooze_cnt_nx = '0;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state              <= ST_IDLE;
      // Held high out of reset so a match level present at release is not an edge.
      match_d            <= 1'b1;
      ring_secs          <= '0;
      rem                <= '0;
      snooze_cnt         <= '0;
      beat               <= 1'b0;
      buzz_q             <= 1'b0;
      o_Ringing          <= 1'b0;
      o_Snoozing         <= 1'b0;
      o_Snooze_Remaining <= '0;
    end else begin
      state              <= state_nx;
      match_d            <= i_Alarm_Match;
      ring_secs          <= ring_secs_nx;
      rem                <= rem_nx;
      snooze_cnt         <= snooze_cnt_nx;
      beat               <= beat_nx;
      buzz_q             <= (state_nx == ST_RINGING) & beat_nx;
      o_Ringing          <= (state_nx == ST_RINGING);
      o_Snoozing         <= (state_nx == ST_SNOOZE);
      o_Snooze_Remaining <= (state_nx == ST_SNOOZE) ? REMAIN_OUT_W'(rem_nx) : '0;
    end
  end

`ifdef ALARM_SNOOZE_TONE_EN
  logic tone;

  // Tone phase restarts whenever ringing begins because the divider idles outside RINGING.
  tone_gen #(
    .CLK_IN  (CLK_IN),
    .TONE_HZ (TONE_HZ)
  ) u_tone_gen (
    .clk   (i_Clk),
    .rst_n (i_Reset_n),
    .en    (o_Ringing),
    .tone  (tone)
  );

  assign o_Buzzer = buzz_q & tone;
`else
  assign o_Buzzer = buzz_q;
`endif

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl with a 5 s snooze interval.
module tb_alarm_snooze_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Reset_n = 1'b0;
  logic       i_Tick_1Hz = 1'b0;
  logic       i_Alarm_Match = 1'b0;
  logic       i_Alarm_Enable = 1'b1;
  logic       i_Snooze = 1'b0;
  logic       i_Stop = 1'b0;
  logic       o_Buzzer;
  logic       o_Ringing;
  logic       o_Snoozing;
  logic [9:0] o_Snooze_Remaining;

  int total = 0;
  int bad   = 0;

  alarm_snooze_ctrl #(
    .CLK_IN         (5000000),
    .TONE_HZ        (1000),
    .SNOOZE_SECONDS (5),
    .RING_TIMEOUT_S (60),
    .MAX_SNOOZES    (3)
  ) dut (
    .i_Clk              (i_Clk),
    .i_Reset_n          (i_Reset_n),
    .i_Tick_1Hz         (i_Tick_1Hz),
    .i_Alarm_Match      (i_Alarm_Match),
    .i_Alarm_Enable     (i_Alarm_Enable),
    .i_Snooze           (i_Snooze),
    .i_Stop             (i_Stop),
    .o_Buzzer           (o_Buzzer),
    .o_Ringing          (o_Ringing),
    .o_Snoozing         (o_Snoozing),
    .o_Snooze_Remaining (o_Snooze_Remaining)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic tick();
    i_Tick_1Hz = 1'b1;
    step();
    i_Tick_1Hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic snooze();
    i_Snooze = 1'b1;
    step();
    i_Snooze = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_ringing", o_Ringing, 0);
    chk("rst_snoozing", o_Snoozing, 0);
    chk("rst_buzzer", o_Buzzer, 0);
    chk("rst_remaining", o_Snooze_Remaining, 0);
    i_Reset_n = 1'b1;
    step();
    chk("idle_ringing", o_Ringing, 0);

    // Rising match -> ringing one cycle later, beat starts high
    i_Alarm_Match = 1'b1;
    step();
    chk("ring_latency", o_Ringing, 1);
    chk("ring_buzz_entry", o_Buzzer, 1);
    tick();
    chk("beat_tick1", o_Buzzer, 0);
    tick();
    chk("beat_tick2", o_Buzzer, 1);

    // Snooze coinciding with a tick loads 5 undecremented
    i_Snooze = 1'b1;
    i_Tick_1Hz = 1'b1;
    step();
    i_Snooze = 1'b0;
    i_Tick_1Hz = 1'b0;
    chk("snz1_snoozing", o_Snoozing, 1);
    chk("snz1_ringing", o_Ringing, 0);
    chk("snz1_rem5", o_Snooze_Remaining, 5);
    chk("snz1_buzz", o_Buzzer, 0);
    for (int r = 4; r >= 1; r--) begin
      tick();
      chk("snz1_countdown", o_Snooze_Remaining, r);
    end
    snooze();
    chk("snz_ignored_in_snooze", o_Snoozing, 1);
    chk("snz_ignored_rem", o_Snooze_Remaining, 1);
    tick();
    chk("snz1_rering", o_Ringing, 1);
    chk("snz1_rem0", o_Snooze_Remaining, 0);
    chk("snz1_rering_buzz", o_Buzzer, 1);

    // Second and third snoozes
    snooze();
    chk("snz2_snoozing", o_Snoozing, 1);
    ticks(5);
    chk("snz2_rering", o_Ringing, 1);
    snooze();
    chk("snz3_snoozing", o_Snoozing, 1);
    ticks(5);
    chk("snz3_rering", o_Ringing, 1);

    // Fourth snooze ignored; timeout after 60 ticks
    snooze();
    chk("snz4_ignored_snoozing", o_Snoozing, 0);
    chk("snz4_ignored_ringing", o_Ringing, 1);
    ticks(59);
    chk("timeout_59", o_Ringing, 1);
    tick();
    chk("timeout_60_ringing", o_Ringing, 0);
    chk("timeout_60_buzz", o_Buzzer, 0);

    // DONE holds while match high, then new event has a fresh snooze budget
    step();
    step();
    chk("done_hold", o_Ringing, 0);
    i_Alarm_Match = 1'b0;
    step();
    i_Alarm_Match = 1'b1;
    step();
    chk("retrigger", o_Ringing, 1);
    snooze();
    chk("snooze_count_cleared", o_Snoozing, 1);

    // Stop during snooze -> DONE
    i_Stop = 1'b1;
    step();
    i_Stop = 1'b0;
    chk("stop_in_snooze_snoozing", o_Snoozing, 0);
    chk("stop_in_snooze_rem", o_Snooze_Remaining, 0);
    chk("stop_in_snooze_ringing", o_Ringing, 0);
    i_Alarm_Match = 1'b0;
    step();
    i_Alarm_Match = 1'b1;
    step();
    chk("retrigger2", o_Ringing, 1);

    // Stop and snooze together -> DONE, held while match high
    i_Stop = 1'b1;
    i_Snooze = 1'b1;
    step();
    i_Stop = 1'b0;
    i_Snooze = 1'b0;
    chk("stop_wins_ringing", o_Ringing, 0);
    chk("stop_wins_snoozing", o_Snoozing, 0);
    step();
    step();
    chk("done_hold2", o_Ringing, 0);
    i_Alarm_Match = 1'b0;
    step();
    i_Alarm_Match = 1'b1;
    step();
    chk("retrigger3", o_Ringing, 1);

    // Enable drop during snooze -> IDLE
    snooze();
    tick();
    chk("en_snz_rem4", o_Snooze_Remaining, 4);
    i_Alarm_Enable = 1'b0;
    step();
    chk("en_off_snoozing", o_Snoozing, 0);
    chk("en_off_rem", o_Snooze_Remaining, 0);
    chk("en_off_buzz", o_Buzzer, 0);
    chk("en_off_ringing", o_Ringing, 0);
    i_Alarm_Enable = 1'b1;
    step();
    step();
    chk("en_on_no_edge", o_Ringing, 0);
    i_Alarm_Match = 1'b0;
    step();
    i_Alarm_Match = 1'b1;
    step();
    chk("retrigger4", o_Ringing, 1);

    // Asynchronous reset mid-ring; held match must not re-trigger
    tick();
    tick();
    chk("pre_reset_buzz", o_Buzzer, 1);
    i_Reset_n = 1'b0;
    #1;
    chk("async_rst_ringing", o_Ringing, 0);
    chk("async_rst_buzz", o_Buzzer, 0);
    chk("async_rst_snoozing", o_Snoozing, 0);
    chk("async_rst_rem", o_Snooze_Remaining, 0);
    step();
    i_Reset_n = 1'b1;
    step();
    step();
    step();
    chk("no_retrigger_after_rst", o_Ringing, 0);
    i_Alarm_Match = 1'b0;
    step();
    i_Alarm_Match = 1'b1;
    step();
    chk("retrigger_after_rst", o_Ringing, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
